// File: rtl/enc_secded_stream.sv
// enc_secded_stream: two-stage pipelined SECDED (extended Hamming) encoder on a
// valid/ready stream, with one-shot codeword error injection and a saturating
// delivered-word counter.
module enc_secded_stream #(
  parameter  int DATA_W = 11,
  parameter  int CNT_W  = 16,
  // Smallest p with 2^p >= DATA_W+p+1, valid over DATA_W 1..120.
  localparam int P      = (DATA_W <= 1)  ? 2 :
                          (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 :
                          (DATA_W <= 57) ? 6 : 7,
  localparam int PAR_W  = P + 1,
  localparam int CW     = DATA_W + PAR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              inj_arm,
  input  logic [CW-1:0]     inj_mask,
  output logic              inj_pending,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_code,
  output logic [PAR_W-1:0]  out_parity,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  word_cnt
);

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q;
  logic [CW-1:0]     s1_mask_q;
  logic              out_valid_q;
  logic [CW-1:0]     out_code_q;
  logic [PAR_W-1:0]  out_parity_q;
  logic              inj_pending_q, inj_pending_d;
  logic [CW-1:0]     inj_mask_q, inj_mask_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  logic              en;
  logic              ready;
  logic              accept;
  logic [CW-1:0]     word_mask;
  logic [CW-1:0]     enc_code;
  logic [PAR_W-1:0]  enc_par;

  // Handshake: S2 advances when empty or drained; S1 accepts when it can move on.
  always_comb begin
    en         = !out_valid_q || out_ready;
    ready      = !s1_valid_q || en;
    accept     = in_valid && ready;
    s1_valid_d = ready ? in_valid : s1_valid_q;
    // A same-cycle arm takes priority over a stored mask for the word being accepted.
    word_mask  = inj_arm ? inj_mask : (inj_pending_q ? inj_mask_q : '0);
  end

  // Injection bookkeeping: an accept consumes any pending mask; otherwise arm (re)loads it.
  always_comb begin
    inj_pending_d = inj_pending_q;
    inj_mask_d    = inj_mask_q;
    if (accept) begin
      inj_pending_d = 1'b0;
    end else if (inj_arm) begin
      inj_pending_d = 1'b1;
      inj_mask_d    = inj_mask;
    end
  end

  // Encoder: scatter data into non-power-of-two positions, then fill check bits.
  always_comb begin
    int unsigned j;
    logic        hb;
    enc_code = '0;
    enc_par  = '0;
    j        = 0;
    hb       = 1'b0;
    for (int unsigned k = 1; k < CW; k++) begin
      if ((k & (k - 1)) != 0) begin
        enc_code[k] = s1_data_q[j];
        j++;
      end
    end
    // Check-bit positions are still zero here, so each Hamming bit sees only data.
    for (int unsigned i = 0; i < P; i++) begin
      hb = 1'b0;
      for (int unsigned k = 1; k < CW; k++) begin
        if (k[i]) hb = hb ^ enc_code[k];
      end
      enc_code[1 << i] = hb;
      enc_par[i]       = hb;
    end
    enc_par[P]  = ^enc_code;
    enc_code[0] = enc_par[P];
  end

  // Saturating counter of delivered codewords; clear wins over increment.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (clr_cnt) begin
      word_cnt_d = '0;
    end else if (out_valid_q && out_ready && (word_cnt_q != '1)) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end
  end

  // Stage 1: capture the accepted word together with its injection mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mask_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_data_q <= in_data;
        s1_mask_q <= word_mask;
      end
    end
  end

  // Stage 2: register the (possibly corrupted) codeword and the clean check bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_code_q   <= '0;
      out_parity_q <= '0;
    end else if (en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_code_q   <= enc_code ^ s1_mask_q;
        out_parity_q <= enc_par;
      end
    end
  end

  // Injection state and word counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_pending_q <= 1'b0;
      inj_mask_q    <= '0;
      word_cnt_q    <= '0;
    end else begin
      inj_pending_q <= inj_pending_d;
      inj_mask_q    <= inj_mask_d;
      word_cnt_q    <= word_cnt_d;
    end
  end

  assign in_ready    = ready;
  assign inj_pending = inj_pending_q;
  assign out_valid   = out_valid_q;
  assign out_code    = out_code_q;
  assign out_parity  = out_parity_q;
  assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_enc_secded_stream.sv
// Directed and table-driven bench for enc_secded_stream (DATA_W 11/1/120, CNT_W 16/4).
module tb_enc_secded_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---- instance A: DATA_W=11, CNT_W=16
  logic        a_in_valid, a_in_ready, a_inj_arm, a_inj_pending, a_out_valid, a_out_ready, a_clr;
  logic [10:0] a_in_data;
  logic [15:0] a_inj_mask, a_out_code, a_cnt;
  logic [4:0]  a_out_par;

  enc_secded_stream #(.DATA_W(11), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .inj_arm(a_inj_arm), .inj_mask(a_inj_mask),
    .inj_pending(a_inj_pending), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_code(a_out_code), .out_parity(a_out_par), .clr_cnt(a_clr), .word_cnt(a_cnt));

  // ---- instance B: DATA_W=11, CNT_W=4
  logic        b_in_valid, b_in_ready, b_inj_pending, b_out_valid, b_out_ready, b_clr;
  logic [10:0] b_in_data;
  logic [15:0] b_out_code;
  logic [4:0]  b_out_par;
  logic [3:0]  b_cnt;

  enc_secded_stream #(.DATA_W(11), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .inj_arm(1'b0), .inj_mask(16'h0000),
    .inj_pending(b_inj_pending), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_code(b_out_code), .out_parity(b_out_par), .clr_cnt(b_clr), .word_cnt(b_cnt));

  // ---- instance C: DATA_W=1 (CW=4)
  logic        c_in_valid, c_in_ready, c_inj_pending, c_out_valid;
  logic [0:0]  c_in_data;
  logic [3:0]  c_out_code;
  logic [2:0]  c_out_par;
  logic [15:0] c_cnt;

  enc_secded_stream #(.DATA_W(1), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .inj_arm(1'b0), .inj_mask(4'h0),
    .inj_pending(c_inj_pending), .out_valid(c_out_valid), .out_ready(1'b1),
    .out_code(c_out_code), .out_parity(c_out_par), .clr_cnt(1'b0), .word_cnt(c_cnt));

  // ---- instance D: DATA_W=120 (CW=128)
  logic         d_in_valid, d_in_ready, d_inj_pending, d_out_valid;
  logic [119:0] d_in_data;
  logic [127:0] d_out_code;
  logic [7:0]   d_out_par;
  logic [15:0]  d_cnt;

  enc_secded_stream #(.DATA_W(120), .CNT_W(16)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .inj_arm(1'b0), .inj_mask(128'h0),
    .inj_pending(d_inj_pending), .out_valid(d_out_valid), .out_ready(1'b1),
    .out_code(d_out_code), .out_parity(d_out_par), .clr_cnt(1'b0), .word_cnt(d_cnt));

  // ---- reference model: check bits from the XOR of positions holding a 1
  function automatic int tb_p(input int dw);
    int p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  function automatic logic [127:0] model_code(input int dw, input logic [127:0] d);
    int p, cw, j;
    logic [7:0]   syn;
    logic [127:0] c;
    p = tb_p(dw); cw = dw + p + 1; j = 0; syn = '0; c = '0;
    for (int k = 1; k < cw; k++) begin
      if ($countones(k) != 1) begin
        c[k] = d[j];
        if (d[j]) syn = syn ^ 8'(k);
        j++;
      end
    end
    for (int i = 0; i < p; i++) c[1 << i] = syn[i];
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [7:0] model_par(input int dw, input logic [127:0] d);
    logic [127:0] c;
    logic [7:0]   r;
    int p;
    c = model_code(dw, d); p = tb_p(dw); r = '0;
    for (int i = 0; i < p; i++) r[i] = c[1 << i];
    r[p] = c[0];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [10:0] data;
    logic [15:0] code;
    logic [4:0]  par;
  } vec_t;

  vec_t vecs[3];
  logic [15:0] exp_q[$];
  logic [10:0] x1, x2, x3;
  logic [119:0] dv[4];
  logic [0:0]   cv[2];

  initial begin
    vecs[0] = '{data: 11'h000, code: 16'h0000, par: 5'h00};
    vecs[1] = '{data: 11'h001, code: 16'h000F, par: 5'h13};
    vecs[2] = '{data: 11'h7FF, code: 16'hFFFF, par: 5'h1F};

    a_in_valid = 0; a_in_data = '0; a_inj_arm = 0; a_inj_mask = '0; a_out_ready = 1; a_clr = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 1; b_clr = 0;
    c_in_valid = 0; c_in_data = '0; d_in_valid = 0; d_in_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;

    // reset state
    @(negedge clk);
    check("rst_out_valid", 128'(a_out_valid), 128'(0));
    check("rst_in_ready", 128'(a_in_ready), 128'(1));
    check("rst_pending", 128'(a_inj_pending), 128'(0));
    check("rst_code", 128'(a_out_code), 128'(0));
    check("rst_par", 128'(a_out_par), 128'(0));
    check("rst_cnt", 128'(a_cnt), 128'(0));

    // table vectors with latency check
    for (int v = 0; v < 3; v++) begin
      @(negedge clk); a_in_valid = 1; a_in_data = vecs[v].data;
      @(negedge clk); a_in_valid = 0;
      check("lat_s1_only", 128'(a_out_valid), 128'(0));
      @(negedge clk);
      check("lat_valid", 128'(a_out_valid), 128'(1));
      check("vec_code", 128'(a_out_code), 128'(vecs[v].code));
      check("vec_par", 128'(a_out_par), 128'(vecs[v].par));
    end

    // injection armed while idle
    @(negedge clk); a_inj_arm = 1; a_inj_mask = 16'h0008;
    @(negedge clk); a_inj_arm = 0;
    check("inj_pending_set", 128'(a_inj_pending), 128'(1));
    a_in_valid = 1; a_in_data = 11'h001;
    @(negedge clk); a_in_valid = 0;
    check("inj_pending_clr", 128'(a_inj_pending), 128'(0));
    @(negedge clk);
    check("inj_code", 128'(a_out_code), 128'(16'h0007));
    check("inj_par", 128'(a_out_par), 128'(5'h13));
    @(negedge clk); a_in_valid = 1; a_in_data = 11'h001;
    @(negedge clk); a_in_valid = 0;
    @(negedge clk);
    check("inj_followup", 128'(a_out_code), 128'(16'h000F));

    // injection coincident with accept
    @(negedge clk); a_inj_arm = 1; a_inj_mask = 16'h8001; a_in_valid = 1; a_in_data = 11'h7FF;
    @(negedge clk); a_inj_arm = 0; a_in_valid = 0;
    check("inj_same_pending", 128'(a_inj_pending), 128'(0));
    @(negedge clk);
    check("inj_same_code", 128'(a_out_code), 128'(16'h7FFE));
    check("inj_same_par", 128'(a_out_par), 128'(5'h1F));

    // re-arm while pending replaces the mask
    @(negedge clk); a_inj_arm = 1; a_inj_mask = 16'h0001;
    @(negedge clk); a_inj_mask = 16'h0002;
    @(negedge clk); a_inj_arm = 0;
    check("rearm_pending", 128'(a_inj_pending), 128'(1));
    a_in_valid = 1; a_in_data = 11'h000;
    @(negedge clk); a_in_valid = 0;
    @(negedge clk);
    check("rearm_code", 128'(a_out_code), 128'(16'h0002));

    // back-pressure: both stages full, output held stable
    x1 = 11'h123; x2 = 11'h456; x3 = 11'h789;
    @(negedge clk); a_out_ready = 0; a_in_valid = 1; a_in_data = x1;
    @(negedge clk); a_in_data = x2; #1;
    check("bp_ready_bubble", 128'(a_in_ready), 128'(1));
    @(negedge clk); a_in_data = x3; #1;
    check("bp_ready_full", 128'(a_in_ready), 128'(0));
    check("bp_valid", 128'(a_out_valid), 128'(1));
    check("bp_code0", 128'(a_out_code), model_code(11, 128'(x1)));
    @(negedge clk);
    check("bp_code_hold", 128'(a_out_code), model_code(11, 128'(x1)));
    a_out_ready = 1; #1;
    check("bp_ready_comb", 128'(a_in_ready), 128'(1));
    @(negedge clk); a_in_valid = 0;
    check("bp_code1", 128'(a_out_code), model_code(11, 128'(x2)));
    @(negedge clk);
    check("bp_code2", 128'(a_out_code), model_code(11, 128'(x3)));
    check("bp_par2", 128'(a_out_par), 128'(model_par(11, 128'(x3))));
    @(negedge clk);
    check("bp_drained", 128'(a_out_valid), 128'(0));
    check("cnt_directed", 128'(a_cnt), 128'(10));

    // random stream with random back-pressure
    @(negedge clk); a_clr = 1;
    @(negedge clk); a_clr = 0;
    check("cnt_clr", 128'(a_cnt), 128'(0));
    begin
      int sent, recv, cyc;
      logic [15:0] e;
      sent = 0; recv = 0; cyc = 0;
      while (recv < 1000 && cyc < 20000) begin
        @(negedge clk);
        a_out_ready = 1'($urandom_range(0, 1));
        a_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
        a_in_data   = 11'($urandom);
        #1;
        if (a_out_valid && a_out_ready) begin
          if (exp_q.size() == 0) begin
            check("stream_extra", 128'(1), 128'(0));
          end else begin
            e = exp_q.pop_front();
            check("stream_code", 128'(a_out_code), 128'(e));
          end
          recv++;
        end
        if (a_in_valid && a_in_ready) begin
          exp_q.push_back(model_code(11, 128'(a_in_data)) [15:0]);
          sent++;
        end
        cyc++;
      end
      a_in_valid = 0; a_out_ready = 1;
      check("stream_recv", 128'(recv), 128'(1000));
      check("stream_leftover", 128'(exp_q.size()), 128'(0));
      @(negedge clk);
      check("stream_cnt", 128'(a_cnt), 128'(1000));
      check("stream_no_dup", 128'(a_out_valid), 128'(0));
    end

    // CNT_W=4 saturation
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); b_in_valid = 1; b_in_data = 11'(t);
      if (t == 10) check("b_cnt_mid", 128'(b_cnt), 128'(8));
    end
    @(negedge clk); b_in_valid = 0;
    repeat (3) @(negedge clk);
    check("b_cnt_sat", 128'(b_cnt), 128'(4'hF));
    @(negedge clk); b_in_valid = 1; b_in_data = 11'h001;
    @(negedge clk); b_in_valid = 0;
    @(negedge clk); b_clr = 1;
    check("b_clr_handshake", 128'(b_out_valid), 128'(1));
    @(negedge clk); b_clr = 0;
    check("b_clr_wins", 128'(b_cnt), 128'(0));

    // DATA_W=1 and DATA_W=120
    cv[0] = 1'b0; cv[1] = 1'b1;
    dv[0] = '0; dv[1] = '1;
    dv[2] = 120'({$urandom, $urandom, $urandom, $urandom});
    dv[3] = 120'({$urandom, $urandom, $urandom, $urandom});
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      c_in_valid = 1; c_in_data = cv[v % 2];
      d_in_valid = 1; d_in_data = dv[v];
      @(negedge clk); c_in_valid = 0; d_in_valid = 0;
      @(negedge clk);
      check("c_code", 128'(c_out_code), model_code(1, 128'(cv[v % 2])));
      check("c_par", 128'(c_out_par), 128'(model_par(1, 128'(cv[v % 2]))));
      check("d_code", d_out_code, model_code(120, 128'(dv[v])));
      check("d_par", 128'(d_out_par), 128'(model_par(120, 128'(dv[v]))));
    end

    // reset mid-stream with both stages full and a pending injection
    @(negedge clk); a_out_ready = 0; a_in_valid = 1; a_in_data = 11'h0AA;
    @(negedge clk); a_in_data = 11'h055;
    @(negedge clk); a_in_valid = 0; a_inj_arm = 1; a_inj_mask = 16'h00F0;
    @(negedge clk); a_inj_arm = 0;
    check("mid_pending", 128'(a_inj_pending), 128'(1));
    check("mid_full", 128'(a_in_ready), 128'(0));
    #2 rst_n = 0;
    #1;
    check("mid_rst_valid", 128'(a_out_valid), 128'(0));
    check("mid_rst_ready", 128'(a_in_ready), 128'(1));
    check("mid_rst_pending", 128'(a_inj_pending), 128'(0));
    check("mid_rst_cnt", 128'(a_cnt), 128'(0));
    @(negedge clk); rst_n = 1; a_out_ready = 1;
    @(negedge clk); a_in_valid = 1; a_in_data = 11'h001;
    @(negedge clk); a_in_valid = 0;
    @(negedge clk);
    check("post_rst_code", 128'(a_out_code), 128'(16'h000F));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
